// File: rtl/after_shift_pkg.sv
// Shared width and lane-select encodings for the Booth partial-product preparation stage.
package after_shift_pkg;

  localparam int unsigned WIDTH = 64;

  typedef logic [WIDTH-1:0] word_t;

  // A-lane: encodings 5..7 are unused and produce zero.
  typedef enum logic [2:0] {
    SEL_ZERO = 3'd0,
    SEL_X1   = 3'd1,
    SEL_X2   = 3'd2,
    SEL_X4   = 3'd3,
    SEL_X8   = 3'd4
  } sel_a_e;

  typedef enum logic [1:0] {
    SEL_B_ZERO = 2'd0,
    SEL_B_X1   = 2'd1,
    SEL_B_X2   = 2'd2
  } sel_b_e;

  typedef enum logic {
    SEL_C_ZERO = 1'b0,
    SEL_C_X1   = 1'b1
  } sel_c_e;

endpackage

// File: rtl/adder_subtractor_64.sv
// 64-bit add/subtract unit: Out = A + (B ^ {64{Cin}}) + Cin, modulo 2^64.
module adder_subtractor_64
  import after_shift_pkg::*;
(
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] Out
);

  word_t b_eff;

  always_comb begin
    b_eff = B ^ {WIDTH{Cin}};
    Out   = A + b_eff + WIDTH'(Cin);
  end

endmodule

// File: rtl/after_shift.sv
// Booth partial-product preparation: optional negate of A, then three scaled, registered lanes.
// Optional input register stage enabled by defining AFTER_SHIFT_IN_REG_EN (latency 2 instead of 1).
module after_shift
  import after_shift_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset,
  input  logic [2:0]       SelBoothA,
  input  logic [1:0]       SelBoothB,
  input  logic             SelBoothC,
  input  logic             Sign,
  input  logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] BoothA,
  output logic [WIDTH-1:0] BoothB,
  output logic [WIDTH-1:0] BoothC
);

  logic [2:0] sel_a;
  logic [1:0] sel_b;
  logic       sel_c;
  logic       sign_in;
  word_t      a_in;

`ifdef AFTER_SHIFT_IN_REG_EN
  logic [2:0] sel_a_q;
  logic [1:0] sel_b_q;
  logic       sel_c_q;
  logic       sign_q;
  word_t      a_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sel_a_q <= '0;
      sel_b_q <= '0;
      sel_c_q <= 1'b0;
      sign_q  <= 1'b0;
      a_q     <= '0;
    end else begin
      sel_a_q <= SelBoothA;
      sel_b_q <= SelBoothB;
      sel_c_q <= SelBoothC;
      sign_q  <= Sign;
      a_q     <= A;
    end
  end

  assign sel_a   = sel_a_q;
  assign sel_b   = sel_b_q;
  assign sel_c   = sel_c_q;
  assign sign_in = sign_q;
  assign a_in    = a_q;
`else
  assign sel_a   = SelBoothA;
  assign sel_b   = SelBoothB;
  assign sel_c   = SelBoothC;
  assign sign_in = Sign;
  assign a_in    = A;
`endif

  word_t set_a;

  // Zero on the A input turns the unit into a pass/negate of the operand.
  adder_subtractor_64 u_addsub (
    .A   ('0),
    .B   (a_in),
    .Cin (sign_in),
    .Out (set_a)
  );

  word_t booth_a_d;
  word_t booth_b_d;
  word_t booth_c_d;

  always_comb begin
    booth_a_d = '0;
    case (sel_a)
      SEL_X1:  booth_a_d = set_a;
      SEL_X2:  booth_a_d = set_a << 1;
      SEL_X4:  booth_a_d = set_a << 2;
      SEL_X8:  booth_a_d = set_a << 3;
      default: booth_a_d = '0;
    endcase
  end

  always_comb begin
    booth_b_d = '0;
    case (sel_b)
      SEL_B_X1: booth_b_d = set_a;
      SEL_B_X2: booth_b_d = set_a << 1;
      default:  booth_b_d = '0;
    endcase
  end

  always_comb begin
    booth_c_d = '0;
    if (sel_c == SEL_C_X1) booth_c_d = set_a;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      BoothA <= '0;
      BoothB <= '0;
      BoothC <= '0;
    end else begin
      BoothA <= booth_a_d;
      BoothB <= booth_b_d;
      BoothC <= booth_c_d;
    end
  end

endmodule

// File: tb/tb_after_shift.sv
// Directed self-checking bench for after_shift; expected values are hand-computed constants.
module tb_after_shift;

`ifdef AFTER_SHIFT_IN_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        Clk;
  logic        Reset;
  logic [2:0]  SelBoothA;
  logic [1:0]  SelBoothB;
  logic        SelBoothC;
  logic        Sign;
  logic [63:0] A;
  logic [63:0] BoothA;
  logic [63:0] BoothB;
  logic [63:0] BoothC;

  int n_checks;
  int n_fails;

  after_shift dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .SelBoothA (SelBoothA),
    .SelBoothB (SelBoothB),
    .SelBoothC (SelBoothC),
    .Sign      (Sign),
    .A         (A),
    .BoothA    (BoothA),
    .BoothB    (BoothB),
    .BoothC    (BoothC)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  logic [63:0] pa  [8];
  logic        ps  [8];
  logic [63:0] pex [8];
  logic [63:0] exp_a [8];
  logic [63:0] exp_b [3];
  logic [63:0] exp_c [2];

  initial begin
    n_checks = 0;
    n_fails  = 0;

    exp_a = '{64'd0, 64'd1, 64'd2, 64'd4, 64'd8, 64'd0, 64'd0, 64'd0};
    exp_b = '{64'd0, 64'd1, 64'd2};
    exp_c = '{64'd0, 64'd1};

    // Reset with live, nonzero inputs.
    Reset = 1'b1; A = 64'd1; Sign = 1'b0;
    SelBoothA = 3'd4; SelBoothB = 2'd2; SelBoothC = 1'b1;
    tick(2);
    check("reset_a", BoothA, 64'd0);
    check("reset_b", BoothB, 64'd0);
    check("reset_c", BoothC, 64'd0);
    Reset = 1'b0;
    tick(LAT);
    check("release_a", BoothA, 64'd8);
    check("release_b", BoothB, 64'd2);
    check("release_c", BoothC, 64'd1);

    // A-lane sweep, A=1.
    for (int s = 0; s < 8; s++) begin
      SelBoothA = 3'(s);
      tick(LAT);
      check($sformatf("sweep_a%0d", s), BoothA, exp_a[s]);
    end

    // B-lane sweep incl. unused encoding 3.
    for (int s = 0; s < 4; s++) begin
      SelBoothB = 2'(s);
      tick(LAT);
      check($sformatf("sweep_b%0d", s), BoothB, (s == 3) ? 64'd0 : exp_b[s]);
    end

    for (int s = 0; s < 2; s++) begin
      SelBoothC = 1'(s);
      tick(LAT);
      check($sformatf("sweep_c%0d", s), BoothC, exp_c[s]);
    end

    // Negation of 1 with each lane scaled.
    Sign = 1'b1; A = 64'd1; SelBoothA = 3'd4; SelBoothB = 2'd2; SelBoothC = 1'b1;
    tick(LAT);
    check("neg1_a", BoothA, 64'hFFFF_FFFF_FFFF_FFF8);
    check("neg1_b", BoothB, 64'hFFFF_FFFF_FFFF_FFFE);
    check("neg1_c", BoothC, 64'hFFFF_FFFF_FFFF_FFFF);

    // Most-negative operand negates to itself; shifting it left drops the only set bit.
    A = 64'h8000_0000_0000_0000; SelBoothA = 3'd2;
    tick(LAT);
    check("minneg_c", BoothC, 64'h8000_0000_0000_0000);
    check("minneg_a", BoothA, 64'd0);
    check("minneg_b", BoothB, 64'd0);

    A = 64'd0;
    tick(LAT);
    check("negzero_a", BoothA, 64'd0);
    check("negzero_b", BoothB, 64'd0);
    check("negzero_c", BoothC, 64'd0);

    // Back-to-back operand/sign changes; pex is the hand-computed SetA.
    pa[0] = 64'h5;                   ps[0] = 1'b0; pex[0] = 64'h5;
    pa[1] = 64'h5;                   ps[1] = 1'b1; pex[1] = 64'hFFFF_FFFF_FFFF_FFFB;
    pa[2] = 64'h1234;                ps[2] = 1'b0; pex[2] = 64'h1234;
    pa[3] = 64'hFFFF_FFFF_FFFF_FFFF; ps[3] = 1'b1; pex[3] = 64'h1;
    pa[4] = 64'h0;                   ps[4] = 1'b1; pex[4] = 64'h0;
    pa[5] = 64'h8000_0000_0000_0000; ps[5] = 1'b1; pex[5] = 64'h8000_0000_0000_0000;
    pa[6] = 64'h7FFF_FFFF_FFFF_FFFF; ps[6] = 1'b1; pex[6] = 64'h8000_0000_0000_0001;
    pa[7] = 64'hDEAD_BEEF_0000_0001; ps[7] = 1'b0; pex[7] = 64'hDEAD_BEEF_0000_0001;
    SelBoothA = 3'd3; SelBoothB = 2'd2; SelBoothC = 1'b1;
    for (int i = 0; i < 8 + LAT - 1; i++) begin
      if (i < 8) begin
        A = pa[i];
        Sign = ps[i];
      end
      tick(1);
      if (i - (LAT - 1) >= 0) begin
        check($sformatf("pipe%0d_a", i - (LAT - 1)), BoothA, pex[i - (LAT - 1)] << 2);
        check($sformatf("pipe%0d_b", i - (LAT - 1)), BoothB, pex[i - (LAT - 1)] << 1);
        check($sformatf("pipe%0d_c", i - (LAT - 1)), BoothC, pex[i - (LAT - 1)]);
      end
    end

    // Mid-stream reset wins over live data.
    A = 64'h3; Sign = 1'b0; Reset = 1'b1;
    tick(1);
    check("midreset_a", BoothA, 64'd0);
    check("midreset_b", BoothB, 64'd0);
    check("midreset_c", BoothC, 64'd0);
    Reset = 1'b0;
    tick(LAT);
    check("resume_a", BoothA, 64'hC);
    check("resume_b", BoothB, 64'h6);
    check("resume_c", BoothC, 64'h3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
